// File: rtl/sha1_pkg.sv
// Shared types, constants and round helpers for the SHA-1 compression engine.
package sha1_pkg;

   localparam int unsigned WORD_W    = 32;
   localparam int unsigned NUM_WORDS = 16;
   localparam int unsigned SLOT_W    = 4;
   localparam int unsigned MSG_W     = 512;
   localparam int unsigned DIGEST_W  = 160;
   localparam int unsigned IDX_W     = 7;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ROUND,
      ST_FINAL,
      ST_DONE
   } state_e;

   // Working variables; a occupies the MSBs.
   typedef struct packed {
      word_t a;
      word_t b;
      word_t c;
      word_t d;
      word_t e;
   } work_t;

   // Chaining digest; h0 occupies [159:128] so it maps straight onto the port.
   typedef struct packed {
      word_t h0;
      word_t h1;
      word_t h2;
      word_t h3;
      word_t h4;
   } digest_t;

   localparam word_t H0_INIT = 32'h6745_2301;
   localparam word_t H1_INIT = 32'hEFCD_AB89;
   localparam word_t H2_INIT = 32'h98BA_DCFE;
   localparam word_t H3_INIT = 32'h1032_5476;
   localparam word_t H4_INIT = 32'hC3D2_E1F0;

   localparam word_t K_00_19 = 32'h5A82_7999;
   localparam word_t K_20_39 = 32'h6ED9_EBA1;
   localparam word_t K_40_59 = 32'h8F1B_BCDC;
   localparam word_t K_60_79 = 32'hCA62_C1D6;

   function automatic word_t rotl(input word_t x, input int unsigned n);
      rotl = (x << n) | (x >> (WORD_W - n));
   endfunction

   function automatic word_t f_ch(input word_t b, input word_t c, input word_t d);
      f_ch = (b & c) | (~b & d);
   endfunction

   function automatic word_t f_par(input word_t b, input word_t c, input word_t d);
      f_par = b ^ c ^ d;
   endfunction

   function automatic word_t f_maj(input word_t b, input word_t c, input word_t d);
      f_maj = (b & c) | (b & d) | (c & d);
   endfunction

endpackage

// File: rtl/sha1_w_sched.sv
// 16x32 message-schedule ring: block load, W select and in-place expansion.
module sha1_w_sched
   import sha1_pkg::*;
(
   input  logic               wb_clk_i,
   input  logic               reset,
   input  logic               load,
   input  logic [MSG_W-1:0]   message,
   input  logic               round_en,
   input  logic [IDX_W-1:0]   t,
   output word_t              w_c
);

   word_t             ring_q [NUM_WORDS];
   word_t             ring_d [NUM_WORDS];
   logic [SLOT_W-1:0] slot_c;
   logic [SLOT_W-1:0] idx3_c;
   logic [SLOT_W-1:0] idx8_c;
   logic [SLOT_W-1:0] idx14_c;
   word_t             expand_c;

   // Modulo-16 ring indices fall out of 4-bit wrap-around subtraction.
   always_comb begin
      slot_c   = t[SLOT_W-1:0];
      idx3_c   = slot_c - SLOT_W'(3);
      idx8_c   = slot_c - SLOT_W'(8);
      idx14_c  = slot_c - SLOT_W'(14);
      expand_c = rotl(ring_q[idx3_c] ^ ring_q[idx8_c] ^ ring_q[idx14_c] ^ ring_q[slot_c], 1);
      w_c      = (t < IDX_W'(NUM_WORDS)) ? ring_q[slot_c] : expand_c;

      ring_d = ring_q;
      if (load) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            ring_d[i] = message[MSG_W-1-WORD_W*i -: WORD_W];
         end
      end else if (round_en && (t >= IDX_W'(NUM_WORDS))) begin
         ring_d[slot_c] = expand_c;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (reset) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            ring_q[i] <= '0;
         end
      end else begin
         ring_q <= ring_d;
      end
   end

endmodule

// File: rtl/sha1_round_ctrl.sv
// SHA-1 block sequencer: accepts a 512-bit block, runs the rounds one per clock
// and folds the result into the chaining digest.
module sha1_round_ctrl
   import sha1_pkg::*;
#(
   parameter int unsigned ROUNDS = 80
)
(
   input  logic                wb_clk_i,
   input  logic                reset,
   input  logic                start,
   input  logic                chain,
   input  logic [MSG_W-1:0]    message,
   output logic                busy,
   output logic                done,
   output logic                panic,
   output logic [IDX_W-1:0]    loop_idx,
   output logic [DIGEST_W-1:0] digest
);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] t_q, t_d;
   work_t            work_q, work_d;
   digest_t          h_q, h_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             panic_q, panic_d;
   logic [IDX_W-1:0] loop_idx_q, loop_idx_d;

   logic             accept_c;
   logic             round_en_c;
   word_t            w_c;
   word_t            f_c;
   word_t            k_c;
   word_t            temp_c;

   sha1_w_sched u_w_sched (
      .wb_clk_i (wb_clk_i),
      .reset    (reset),
      .load     (accept_c),
      .message  (message),
      .round_en (round_en_c),
      .t        (t_q),
      .w_c      (w_c)
   );

   // Round function and constant selected by round index.
   always_comb begin
      f_c = f_par(work_q.b, work_q.c, work_q.d);
      k_c = K_60_79;
      if (t_q < IDX_W'(20)) begin
         f_c = f_ch(work_q.b, work_q.c, work_q.d);
         k_c = K_00_19;
      end else if (t_q < IDX_W'(40)) begin
         k_c = K_20_39;
      end else if (t_q < IDX_W'(60)) begin
         f_c = f_maj(work_q.b, work_q.c, work_q.d);
         k_c = K_40_59;
      end
      temp_c = rotl(work_q.a, 5) + f_c + work_q.e + k_c + w_c;
   end

   always_comb begin
      state_d    = state_q;
      t_d        = t_q;
      work_d     = work_q;
      h_d        = h_q;
      done_d     = done_q;
      panic_d    = panic_q;
      accept_c   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
      round_en_c = (state_q == ST_ROUND);

      // A start that lands while the engine is working is dropped and flagged.
      if (start && !accept_c) begin
         panic_d = 1'b1;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_LOAD;
               done_d  = 1'b0;
               panic_d = 1'b0;
               if (!chain) begin
                  h_d.h0 = H0_INIT;
                  h_d.h1 = H1_INIT;
                  h_d.h2 = H2_INIT;
                  h_d.h3 = H3_INIT;
                  h_d.h4 = H4_INIT;
               end
            end
         end
         ST_LOAD: begin
            work_d.a = h_q.h0;
            work_d.b = h_q.h1;
            work_d.c = h_q.h2;
            work_d.d = h_q.h3;
            work_d.e = h_q.h4;
            t_d      = '0;
            state_d  = ST_ROUND;
         end
         ST_ROUND: begin
            work_d.e = work_q.d;
            work_d.d = work_q.c;
            work_d.c = rotl(work_q.b, 30);
            work_d.b = work_q.a;
            work_d.a = temp_c;
            if (t_q == IDX_W'(ROUNDS - 1)) begin
               state_d = ST_FINAL;
            end else begin
               t_d = t_q + IDX_W'(1);
            end
         end
         ST_FINAL: begin
            h_d.h0  = h_q.h0 + work_q.a;
            h_d.h1  = h_q.h1 + work_q.b;
            h_d.h2  = h_q.h2 + work_q.c;
            h_d.h3  = h_q.h3 + work_q.d;
            h_d.h4  = h_q.h4 + work_q.e;
            done_d  = 1'b1;
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Status outputs are decoded from the next state so they stay registered.
      busy_d = (state_d == ST_LOAD) || (state_d == ST_ROUND) || (state_d == ST_FINAL);
      case (state_d)
         ST_ROUND:          loop_idx_d = t_d;
         ST_FINAL, ST_DONE: loop_idx_d = IDX_W'(ROUNDS);
         default:           loop_idx_d = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         t_q        <= '0;
         work_q     <= '0;
         h_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         panic_q    <= 1'b0;
         loop_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         t_q        <= t_d;
         work_q     <= work_d;
         h_q        <= h_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         panic_q    <= panic_d;
         loop_idx_q <= loop_idx_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign panic    = panic_q;
   assign loop_idx = loop_idx_q;
   assign digest   = h_q;

endmodule

// File: tb/tb_sha1_round_ctrl.sv
// Scoreboard bench for sha1_round_ctrl: stimulus pushes expected results,
// a monitor pops and compares them whenever done rises.
module tb_sha1_round_ctrl;

   localparam logic [511:0] MSG_ABC   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] MSG_EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] MSG_TWO_1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] MSG_TWO_2 = {480'h0, 32'h000001c0};

   localparam logic [159:0] DIG_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
   localparam logic [159:0] DIG_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
   localparam logic [159:0] DIG_TWO   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

   logic         wb_clk_i = 1'b0;
   logic         reset;
   logic         start;
   logic         chain;
   logic [511:0] message;
   logic         busy;
   logic         done;
   logic         panic;
   logic [6:0]   loop_idx;
   logic [159:0] digest;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      string        name;
      bit           chk_digest;
      logic [159:0] digest;
      int           acc;
   } exp_t;

   exp_t sb_q[$];

   sha1_round_ctrl #(.ROUNDS(80)) dut (
      .wb_clk_i (wb_clk_i),
      .reset    (reset),
      .start    (start),
      .chain    (chain),
      .message  (message),
      .busy     (busy),
      .done     (done),
      .panic    (panic),
      .loop_idx (loop_idx),
      .digest   (digest)
   );

   always #5 wb_clk_i = ~wb_clk_i;
   always @(posedge wb_clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic check_idle_zero(input string name);
      check({name, "_busy"},     busy,     0);
      check({name, "_done"},     done,     0);
      check({name, "_panic"},    panic,    0);
      check({name, "_loop_idx"}, loop_idx, 0);
      check({name, "_digest"},   digest,   0);
   endtask

   // Called at a negedge; the posedge inside is the accepting edge.
   task automatic issue(input logic [511:0] msg, input logic ch, output int acc);
      start   = 1'b1;
      chain   = ch;
      message = msg;
      @(negedge wb_clk_i);
      acc     = cyc;
      start   = 1'b0;
      chain   = 1'b0;
      message = ~msg;
   endtask

   task automatic push(input string name, input bit chk, input logic [159:0] dig, input int acc);
      exp_t e;
      e.name       = name;
      e.chk_digest = chk;
      e.digest     = dig;
      e.acc        = acc;
      sb_q.push_back(e);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (!done && n < 200) begin
         @(negedge wb_clk_i);
         n++;
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: done=0 after %0d cycles, required done=1", name, n);
      end
   endtask

   task automatic wait_idx(input string name, input logic [6:0] idx);
      int n = 0;
      while (loop_idx != idx && n < 200) begin
         @(negedge wb_clk_i);
         n++;
      end
      if (loop_idx != idx) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: loop_idx=%0d after %0d cycles, required %0d", name, loop_idx, n, idx);
      end
   endtask

   // Monitor: every rising done retires the oldest expected result.
   initial begin
      logic done_prev = 1'b0;
      forever begin
         @(negedge wb_clk_i);
         if (done && !done_prev) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected_done: got done with empty queue, required no done");
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check({e.name, "_latency"}, cyc - e.acc, 82);
               check({e.name, "_busy_at_done"}, busy, 0);
               check({e.name, "_loop_idx_at_done"}, loop_idx, 80);
               if (e.chk_digest) check({e.name, "_digest"}, digest, e.digest);
            end
         end
         done_prev = done;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int acc;
      int bad;
      reset   = 1'b1;
      start   = 1'b0;
      chain   = 1'b0;
      message = '0;
      repeat (3) @(negedge wb_clk_i);
      check_idle_zero("reset");
      reset = 1'b0;
      @(negedge wb_clk_i);

      // "abc" with loop_idx trace
      issue(MSG_ABC, 1'b0, acc);
      push("abc", 1'b1, DIG_ABC, acc);
      check("abc_busy_load", busy, 1);
      check("abc_idx_load", loop_idx, 0);
      bad = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge wb_clk_i);
         if (loop_idx != 7'(k)) bad++;
      end
      check("abc_loop_idx_seq_errors", bad, 0);
      @(negedge wb_clk_i);
      check("abc_idx_final", loop_idx, 80);
      check("abc_busy_final", busy, 1);
      wait_done("abc");
      repeat (3) @(negedge wb_clk_i);
      check("abc_done_held", done, 1);

      // empty message
      issue(MSG_EMPTY, 1'b0, acc);
      push("empty", 1'b1, DIG_EMPTY, acc);
      check("empty_done_cleared", done, 0);
      wait_done("empty");

      // two-block message, second block chained
      issue(MSG_TWO_1, 1'b0, acc);
      push("two_blk1", 1'b0, '0, acc);
      wait_done("two_blk1");
      issue(MSG_TWO_2, 1'b1, acc);
      push("two_blk2", 1'b1, DIG_TWO, acc);
      wait_done("two_blk2");

      // start while busy raises panic, digest unaffected
      issue(MSG_ABC, 1'b0, acc);
      push("panic_abc", 1'b1, DIG_ABC, acc);
      wait_idx("panic_wait40", 7'd40);
      start   = 1'b1;
      message = MSG_EMPTY;
      @(negedge wb_clk_i);
      start   = 1'b0;
      check("panic_set", panic, 1);
      check("panic_busy_kept", busy, 1);
      check("panic_idx_advanced", loop_idx, 41);
      wait_done("panic_abc");
      check("panic_sticky", panic, 1);
      issue(MSG_EMPTY, 1'b0, acc);
      push("panic_clear_empty", 1'b1, DIG_EMPTY, acc);
      check("panic_cleared", panic, 0);
      wait_done("panic_clear_empty");

      // reset mid-operation
      issue(MSG_ABC, 1'b0, acc);
      wait_idx("reset_wait50", 7'd50);
      reset = 1'b1;
      @(negedge wb_clk_i);
      reset = 1'b0;
      check_idle_zero("midreset");
      issue(MSG_ABC, 1'b0, acc);
      push("after_reset_abc", 1'b1, DIG_ABC, acc);
      wait_done("after_reset_abc");

      // back-to-back: start in the first DONE cycle
      issue(MSG_ABC, 1'b0, acc);
      push("b2b_first", 1'b1, DIG_ABC, acc);
      wait_done("b2b_first");
      issue(MSG_EMPTY, 1'b0, acc);
      push("b2b_second", 1'b1, DIG_EMPTY, acc);
      check("b2b_done_fall", done, 0);
      check("b2b_busy_rise", busy, 1);
      wait_done("b2b_second");

      repeat (5) @(negedge wb_clk_i);
      check("sb_drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
